// File: rtl/button_step_gen.sv
// Push-button conditioner: 2-flop synchronizer, counting debouncer, and a press/hold/repeat
// FSM that emits single-cycle step pulses for a downstream counter enable.
module button_step_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16,
  parameter int unsigned TIMER_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic step,
  output logic btn_level,
  output logic holding
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  localparam logic [TIMER_W-1:0] DbLast    = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DelayLoad = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PerLoad   = TIMER_W'(REPEAT_PERIOD - 1);

  logic               sync1, sync2;
  logic [TIMER_W-1:0] db_cnt, rpt_cnt;
  logic [1:0]         state;
  logic               differ, commit, rise_commit, fall_commit;

  assign differ      = (sync2 != btn_level);
  assign commit      = differ && (db_cnt == DbLast);
  assign rise_commit = commit && sync2;
  assign fall_commit = commit && !sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (!differ) begin
        db_cnt <= '0;
      end else if (commit) begin
        btn_level <= sync2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // step is a default-low registered pulse; every branch that fires it reloads a nonzero timer,
  // so two back-to-back pulses cannot occur.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      step    <= 1'b0;
      holding <= 1'b0;
    end else begin
      step <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise_commit) begin
            step    <= 1'b1;
            rpt_cnt <= DelayLoad;
            state   <= HOLD;
            holding <= 1'b1;
          end
        end
        HOLD: begin
          if (fall_commit) begin
            rpt_cnt <= '0;
            state   <= IDLE;
            holding <= 1'b0;
          end else if (rpt_cnt != '0) begin
            rpt_cnt <= rpt_cnt - 1'b1;
          end else if (repeat_en) begin
            step    <= 1'b1;
            rpt_cnt <= PerLoad;
            state   <= REPEAT;
          end
        end
        REPEAT: begin
          if (fall_commit) begin
            rpt_cnt <= '0;
            state   <= IDLE;
            holding <= 1'b0;
          end else if (!repeat_en) begin
            // Parked in HOLD with an expired timer so pulses resume as soon as enabled again.
            rpt_cnt <= '0;
            state   <= HOLD;
          end else if (rpt_cnt == '0) begin
            step    <= 1'b1;
            rpt_cnt <= PerLoad;
          end else begin
            rpt_cnt <= rpt_cnt - 1'b1;
          end
        end
        default: begin
          rpt_cnt <= '0;
          state   <= IDLE;
          holding <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_step_gen.sv
// Randomized and directed bench for button_step_gen against a time-stamp based reference model.
module tb_button_step_gen;

  localparam int unsigned DEB = 4;
  localparam int unsigned DLY = 8;
  localparam int unsigned PER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic repeat_en = 1'b0;
  logic step, btn_level, holding;

  button_step_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER),
    .TIMER_W        (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .repeat_en(repeat_en),
    .step     (step),
    .btn_level(btn_level),
    .holding  (holding)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: absolute edge times, not timer countdowns.
  int   ecnt = 0;
  bit   hist[2] = '{1'b0, 1'b0};  // hist[1] is the input sampled two edges ago
  bit   m_level = 0, m_held = 0, m_rep = 0, m_step = 0;
  int   m_run = 0, m_due = 0;
  int   pulse_log[$];
  int   base = 0;
  logic [3:0] cnt4 = '0;

  initial forever begin
    @(posedge clk);
    ecnt++;
    m_step = 0;
    if (rst) begin
      hist = '{1'b0, 1'b0};
      m_level = 0; m_held = 0; m_rep = 0; m_run = 0; m_due = 0;
    end else begin
      bit s2, com;
      s2 = hist[1];
      hist[1] = hist[0];
      hist[0] = btn_in;
      m_run = (s2 != m_level) ? m_run + 1 : 0;
      com = (m_run == DEB);
      if (com) begin
        m_level = s2;
        m_run = 0;
      end
      if (!m_held) begin
        if (com && s2) begin
          m_step = 1; m_held = 1; m_rep = 0; m_due = ecnt + DLY;
        end
      end else if (com) begin
        m_held = 0; m_rep = 0;
      end else if (!repeat_en) begin
        if (m_rep) begin
          m_rep = 0; m_due = ecnt + 1;
        end
      end else if (ecnt >= m_due) begin
        m_step = 1; m_rep = 1; m_due = ecnt + PER;
      end
    end
  end

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecnt, act, exp);
    end
  endtask

  // Single compare process: every cycle, between edges.
  initial forever begin
    @(negedge clk);
    check("step", int'(step), int'(m_step));
    check("btn_level", int'(btn_level), int'(m_level));
    check("holding", int'(holding), int'(m_held));
    if (step === 1'b1) begin
      pulse_log.push_back(ecnt - base);
      cnt4 = cnt4 + 4'd1;
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(bit b);
    rst = 1'b1;
    btn_in = b;
    run(2);
    rst = 1'b0;
    base = ecnt;
    pulse_log.delete();
    cnt4 = '0;
  endtask

  initial begin
    // Reset with button held; first pulse only 6 edges after release, repeat disabled.
    #1;
    repeat_en = 1'b0;
    do_reset(1'b1);
    run(20);
    check("clean_count", pulse_log.size(), 1);
    if (pulse_log.size() > 0) check("clean_first", pulse_log[0], 6);
    check("clean_level", int'(btn_level), 1);

    // Bounce: 1,0,1,1,0 then stable 1.
    do_reset(1'b0);
    begin
      bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
        btn_in = pat[i];
        run(1);
      end
    end
    btn_in = 1'b1;
    run(25);
    check("bounce_count", pulse_log.size(), 1);
    if (pulse_log.size() > 0) check("bounce_first", pulse_log[0], 11);

    // Auto-repeat: pulses at 6, 14, 17, 20, 23, 26.
    repeat_en = 1'b1;
    do_reset(1'b1);
    run(26);
    check("rpt_count", pulse_log.size(), 6);
    if (pulse_log.size() >= 3) begin
      check("rpt_delay", pulse_log[1] - pulse_log[0], 8);
      check("rpt_period", pulse_log[2] - pulse_log[1], 3);
    end
    check("rpt_counter", int'(cnt4), 6);

    // Release early in the delay: falling commit at edge 12, before the expiry at 14.
    do_reset(1'b1);
    run(6);
    btn_in = 1'b0;
    run(14);
    check("early_rel_count", pulse_log.size(), 1);
    check("early_rel_hold", int'(holding), 0);

    // Falling commit lands on the expiry edge (14): release wins.
    do_reset(1'b1);
    run(8);
    btn_in = 1'b0;
    run(14);
    check("coinc_count", pulse_log.size(), 1);
    check("coinc_hold", int'(holding), 0);

    // Reset mid-period in REPEAT: pulse at 14, reset sampled at edges 16-17.
    do_reset(1'b1);
    run(15);
    rst = 1'b1;
    run(1);
    check("rst_rpt_hold", int'(holding), 0);
    run(1);
    rst = 1'b0;
    btn_in = 1'b0;
    run(6);
    check("rst_rpt_count", pulse_log.size(), 2);

    // Random bursts of bouncy input, occasional repeat_en toggles and rare resets.
    for (int i = 0; i < 300; i++) begin
      int len;
      len = $urandom_range(1, 24);
      btn_in = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) repeat_en = ~repeat_en;
      rst = ($urandom_range(0, 40) == 0);
      run(1);
      rst = 1'b0;
      run(len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
